// File: rtl/axis_video_gen.sv
// AXI4-Stream video frame source: ramp or memory pixels,
// line/frame gaps, backpressure and one-shot tuser/tlast drops.
module axis_video_gen #(
  parameter int N         = 8,
  parameter int CHANNELS  = 3,
  parameter int WIDTH     = 10,
  parameter int HEIGHT    = 10,
  parameter int LINE_GAP  = 4,
  parameter int FRAME_GAP = 10,
  parameter int ADDR_W    = 20
) (
  input  logic                  sys_clk,
  input  logic                  sys_aresetn,
  input  logic                  en,
  input  logic [7:0]            num_frames,
  input  logic                  mode,
  input  logic                  inject_tuser_drop,
  input  logic                  inject_tlast_drop,
  output logic [ADDR_W-1:0]     pix_addr,
  input  logic [CHANNELS*N-1:0] pix_rdata,
  output logic [CHANNELS*N-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int DW   = CHANNELS * N;
  localparam int XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int GMAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;
  localparam logic [XW-1:0] XL = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YL = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_LGAP,
    S_FGAP
  } state_t;

  state_t        state, state_d;
  logic [XW-1:0] cur_x, nx;
  logic [YW-1:0] cur_y, ny;
  logic [GW-1:0] gap, gap_d;
  logic [7:0]    fs, fs_d, fs_inc, nf;
  logic          tu_arm, tl_arm;
  logic          cur_tu_drop, cur_tl_drop;
  logic          load, start;
  logic          accept, last_x, last_y;
  logic          stop_a, stop_g;
  logic          ld_sof, ld_eol;
  logic [DW-1:0] ramp, data_ld;

  assign accept = m_axis_tvalid & m_axis_tready;
  assign last_x = (cur_x == XL);
  assign last_y = (cur_y == YL);
  assign fs_inc = (fs == 8'hFF) ? fs : fs + 8'd1;
  assign stop_a = !en || ((nf != 8'd0) && (fs_inc == nf));
  assign stop_g = !en || ((nf != 8'd0) && (fs == nf));
  assign ld_sof = (nx == '0) && (ny == '0);
  assign ld_eol = (nx == XL);

  assign busy       = (state != S_IDLE);
  assign frame_done = accept & last_x & last_y;
  assign pix_addr   = ADDR_W'(ny) * ADDR_W'(WIDTH)
                    + ADDR_W'(nx);

  // ramp pattern for the beat being loaded
  always_comb begin
    ramp = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ramp[c*N +: N] = N'(32'(nx) + 32'(ny) + c);
    end
  end

  assign data_ld = mode ? ramp : pix_rdata;

  // next-state, load strobe and next beat coordinates
  always_comb begin
    state_d = state;
    gap_d   = gap;
    fs_d    = fs;
    load    = 1'b0;
    start   = 1'b0;
    nx      = '0;
    ny      = '0;
    unique case (state)
      S_IDLE: begin
        if (en) begin
          start   = 1'b1;
          load    = 1'b1;
          fs_d    = '0;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          if (!last_x) begin
            load = 1'b1;
            nx   = cur_x + XW'(1);
            ny   = cur_y;
          end else if (!last_y) begin
            if (LINE_GAP == 0) begin
              load = 1'b1;
              ny   = cur_y + YW'(1);
            end else begin
              state_d = S_LGAP;
              gap_d   = GW'(LINE_GAP - 1);
            end
          end else begin
            fs_d = fs_inc;
            if (FRAME_GAP != 0) begin
              state_d = S_FGAP;
              gap_d   = GW'(FRAME_GAP - 1);
            end else if (stop_a) begin
              state_d = S_IDLE;
            end else begin
              load = 1'b1;
            end
          end
        end
      end
      S_LGAP: begin
        if (gap == '0) begin
          load    = 1'b1;
          ny      = cur_y + YW'(1);
          state_d = S_ACTIVE;
        end else begin
          gap_d = gap - GW'(1);
        end
      end
      S_FGAP: begin
        if (gap == '0) begin
          if (stop_g) begin
            state_d = S_IDLE;
          end else begin
            load    = 1'b1;
            state_d = S_ACTIVE;
          end
        end else begin
          gap_d = gap - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, counters and run length latch
  always_ff @(posedge sys_clk or negedge sys_aresetn) begin
    if (!sys_aresetn) begin
      state <= S_IDLE;
      gap   <= '0;
      fs    <= '0;
      nf    <= '0;
    end else begin
      state <= state_d;
      gap   <= gap_d;
      fs    <= fs_d;
      if (start) nf <= num_frames;
    end
  end

  // output register: load when empty or draining, hold on stall
  always_ff @(posedge sys_clk or negedge sys_aresetn) begin
    if (!sys_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      cur_x         <= '0;
      cur_y         <= '0;
      cur_tu_drop   <= 1'b0;
      cur_tl_drop   <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= data_ld;
      m_axis_tlast  <= ld_eol & ~tl_arm;
      m_axis_tuser  <= ld_sof & ~tu_arm;
      cur_x         <= nx;
      cur_y         <= ny;
      cur_tu_drop   <= ld_sof & tu_arm;
      cur_tl_drop   <= ld_eol & tl_arm;
    end else if (accept) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // sticky drop flags; a pulse wins over a same-cycle clear
  always_ff @(posedge sys_clk or negedge sys_aresetn) begin
    if (!sys_aresetn) begin
      tu_arm <= 1'b0;
      tl_arm <= 1'b0;
    end else begin
      tu_arm <= inject_tuser_drop
              | (tu_arm & ~(accept & cur_tu_drop));
      tl_arm <= inject_tlast_drop
              | (tl_arm & ~(accept & cur_tl_drop));
    end
  end

endmodule

// File: tb/tb_axis_video_gen.sv
// Scoreboard bench for axis_video_gen: directed frames,
// backpressure, run control, drop injection and async reset.
module tb_axis_video_gen;

  typedef struct packed {
    logic [23:0] d;
    logic        l;
    logic        u;
    logic        fd;
  } beat_t;

  logic        sys_clk = 1'b0;
  logic        sys_aresetn = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  num_frames = 8'd0;
  logic        mode = 1'b0;
  logic        itu = 1'b0;
  logic        itl = 1'b0;
  logic [19:0] pix_addr;
  logic [23:0] pix_rdata;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;
  logic        tuser;
  logic        busy;
  logic        frame_done;

  beat_t sb[$];
  int    acc_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    acc_n = 0;
  int    fd_cnt = 0;
  int    idle_cyc = 0;
  bit    rnd_ready = 1'b0;

  function automatic logic [23:0] mem(int a);
    return {8'(a * 3), 8'(a ^ 32'h5A), 8'(a)};
  endfunction

  function automatic logic [23:0] ramp(int x, int y);
    return {8'(x + y + 2), 8'(x + y + 1), 8'(x + y)};
  endfunction

  assign pix_rdata = mem(int'(pix_addr));

  axis_video_gen dut (
    .sys_clk           (sys_clk),
    .sys_aresetn       (sys_aresetn),
    .en                (en),
    .num_frames        (num_frames),
    .mode              (mode),
    .inject_tuser_drop (itu),
    .inject_tlast_drop (itl),
    .pix_addr          (pix_addr),
    .pix_rdata         (pix_rdata),
    .m_axis_tdata      (tdata),
    .m_axis_tvalid     (tvalid),
    .m_axis_tready     (tready),
    .m_axis_tlast      (tlast),
    .m_axis_tuser      (tuser),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push_frame(bit memm, bit drop_u, bit drop_l0);
    beat_t b;
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < 10; x++) begin
        b.d  = memm ? mem(y * 10 + x) : ramp(x, y);
        b.u  = (x == 0 && y == 0) && !drop_u;
        b.l  = (x == 9) && !(drop_l0 && y == 0);
        b.fd = (x == 9 && y == 9);
        sb.push_back(b);
      end
    end
  endtask

  // monitor: pops the scoreboard on every accepted beat
  initial begin : monitor
    beat_t e;
    bit prev_stall;
    logic [23:0] pd;
    logic [1:0] pf;
    prev_stall = 1'b0;
    pd = '0;
    pf = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_aresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(tvalid), 32'd1);
          chk("hold_data", 32'(tdata), 32'(pd));
          chk("hold_flags", 32'({tlast, tuser}), 32'(pf));
        end
        if (frame_done) begin
          fd_cnt++;
          chk("fd_on_accept", 32'(tvalid && tready), 32'd1);
        end
        if (tvalid && tready) begin
          acc_n++;
          acc_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=beat expected=none");
          end else begin
            e = sb.pop_front();
            chk("tdata", 32'(tdata), 32'(e.d));
            chk("tlast", 32'(tlast), 32'(e.l));
            chk("tuser", 32'(tuser), 32'(e.u));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
          end
        end
        prev_stall = tvalid && !tready;
        pd = tdata;
        pf = {tlast, tuser};
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
    if (rnd_ready) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_acc(int n);
    int k = 0;
    while (acc_n < n && k < 3000) begin
      step();
      k++;
    end
    chk("wait_acc_timeout", 32'(acc_n >= n), 32'd1);
  endtask

  task automatic run_to_idle();
    int k = 0;
    do begin
      step();
      k++;
    end while (busy && k < 3000);
    chk("idle_timeout", 32'(busy), 32'd0);
    idle_cyc = cyc;
    en = 1'b0;
  endtask

  task automatic begin_scn();
    acc_n = 0;
    fd_cnt = 0;
    acc_cyc.delete();
  endtask

  task automatic end_scn(string nm, int beats, int fds);
    chk({nm, "_beats"}, 32'(acc_n), 32'(beats));
    chk({nm, "_fd"}, 32'(fd_cnt), 32'(fds));
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_flags", 32'({tlast, tuser, frame_done}), 32'd0);
    chk("rst_addr", 32'(pix_addr), 32'd0);
    step();
    sys_aresetn = 1'b1;
    step();

    // 1: single ramp frame, full throughput
    begin_scn();
    tready = 1'b1;
    mode = 1'b1;
    num_frames = 8'd1;
    push_frame(1'b0, 1'b0, 1'b0);
    en = 1'b1;
    run_to_idle();
    end_scn("s1", 100, 1);
    if (acc_cyc.size() == 100) begin
      chk("s1_line_gap", 32'(acc_cyc[10] - acc_cyc[9]), 32'd5);
      chk("s1_row_beats", 32'(acc_cyc[9] - acc_cyc[0]), 32'd9);
      chk("s1_busy_fall", 32'(idle_cyc - acc_cyc[99]), 32'd11);
    end else begin
      checks++;
      errors++;
      $display("FAIL s1_timing actual=%0d expected=100",
               acc_cyc.size());
    end

    // 2: memory mode under random backpressure
    begin_scn();
    mode = 1'b0;
    rnd_ready = 1'b1;
    push_frame(1'b1, 1'b0, 1'b0);
    en = 1'b1;
    run_to_idle();
    rnd_ready = 1'b0;
    tready = 1'b1;
    end_scn("s2", 100, 1);

    // 3a: three-frame run
    begin_scn();
    mode = 1'b1;
    num_frames = 8'd3;
    for (int f = 0; f < 3; f++) push_frame(1'b0, 1'b0, 1'b0);
    en = 1'b1;
    run_to_idle();
    end_scn("s3a", 300, 3);

    // 3b: unlimited run, en dropped mid frame 2
    begin_scn();
    num_frames = 8'd0;
    for (int f = 0; f < 2; f++) push_frame(1'b0, 1'b0, 1'b0);
    en = 1'b1;
    wait_acc(120);
    en = 1'b0;
    run_to_idle();
    end_scn("s3b", 200, 2);

    // 4: tuser drop armed during frame 1, re-pulsed while armed
    begin_scn();
    num_frames = 8'd3;
    push_frame(1'b0, 1'b0, 1'b0);
    push_frame(1'b0, 1'b1, 1'b0);
    push_frame(1'b0, 1'b0, 1'b0);
    en = 1'b1;
    wait_acc(5);
    itu = 1'b1;
    step();
    itu = 1'b0;
    wait_acc(50);
    itu = 1'b1;
    step();
    itu = 1'b0;
    run_to_idle();
    end_scn("s4", 300, 3);

    // 5: tlast drop armed at (2,0)
    begin_scn();
    num_frames = 8'd1;
    push_frame(1'b0, 1'b0, 1'b1);
    en = 1'b1;
    wait_acc(2);
    itl = 1'b1;
    step();
    itl = 1'b0;
    run_to_idle();
    end_scn("s5", 100, 1);
    if (acc_cyc.size() > 20) begin
      chk("s5_gap0", 32'(acc_cyc[10] - acc_cyc[9]), 32'd5);
      chk("s5_gap1", 32'(acc_cyc[20] - acc_cyc[19]), 32'd5);
    end else begin
      checks++;
      errors++;
      $display("FAIL s5_timing actual=%0d expected=100",
               acc_cyc.size());
    end

    // 6: async reset while stalled on (5,3)
    begin_scn();
    push_frame(1'b0, 1'b0, 1'b0);
    en = 1'b1;
    wait_acc(35);
    tready = 1'b0;
    step();
    chk("s6_stall_beat", 32'(tdata), 32'(ramp(5, 3)));
    #2;
    sys_aresetn = 1'b0;
    #1;
    chk("s6_rst_tvalid", 32'(tvalid), 32'd0);
    chk("s6_rst_tdata", 32'(tdata), 32'd0);
    chk("s6_rst_flags", 32'({tlast, tuser, frame_done}), 32'd0);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    chk("s6_rst_addr", 32'(pix_addr), 32'd0);
    sb.delete();
    step();
    step();
    begin_scn();
    sys_aresetn = 1'b1;
    tready = 1'b1;
    push_frame(1'b0, 1'b0, 1'b0);
    run_to_idle();
    end_scn("s6", 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
